tree_space_allocator: RTL and testbench

TREE_SPACE_ALLOCATOR -- requirements
Module: tree_space_allocator

---
 rtl/tree_space_allocator.sv | 147 ++++++++++++++
 tb/tb_tree_space_allocator.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_space_allocator.sv
// Node slot allocator: a bump pointer hands out fresh slots, a LIFO recycles released ones.
// Optional build macro TREE_SPACE_CHECK_EN adds an allocation bitmap that rejects bogus releases.

module tree_space_allocator #(
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int RAM_DEPTH      = 256
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      tree_mgt_clear,
    input  logic                      tree_mgt_req_valid,
    output logic                      tree_mgt_req_ready,
    output logic [RAM_ADDR_WIDTH-1:0] tree_mgt_req_addr,
    input  logic                      tree_mgt_free_valid,
    output logic                      tree_mgt_free_ready,
    input  logic [RAM_ADDR_WIDTH-1:0] tree_mgt_free_addr,
    output logic                      tree_mgt_full,
    output logic                      tree_mgt_empty,
    output logic [RAM_ADDR_WIDTH:0]   tree_mgt_used,
    output logic                      tree_mgt_err
);

    localparam int            CW        = RAM_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(RAM_DEPTH);
    localparam logic [CW-1:0] ONE       = CW'(1);

    logic [CW-1:0] bump_q, bump_d;
    logic [CW-1:0] sp_q, sp_d;
    logic [CW-1:0] used_q, used_d;
    logic          err_q, err_d;

    logic [RAM_ADDR_WIDTH-1:0] stack_mem [RAM_DEPTH];
    logic                      stack_we;
    logic [RAM_ADDR_WIDTH-1:0] stack_widx;

    logic                      stack_nonempty;
    logic [RAM_ADDR_WIDTH-1:0] top_idx;
    logic [RAM_ADDR_WIDTH-1:0] push_idx;
    logic                      full, empty;
    logic                      alloc_hs, free_hs, free_ok, free_take;
    logic                      misuse;
    logic                      bump_room;

    assign stack_nonempty = (sp_q != '0);
    assign top_idx        = RAM_ADDR_WIDTH'(sp_q - ONE);
    assign push_idx       = sp_q[RAM_ADDR_WIDTH-1:0];
    assign bump_room      = (bump_q < DEPTH_CNT);

    assign full  = (used_q == DEPTH_CNT);
    assign empty = (used_q == '0);

    assign tree_mgt_req_addr   = stack_nonempty ? stack_mem[top_idx] : bump_q[RAM_ADDR_WIDTH-1:0];
    assign tree_mgt_req_ready  = !full;
    assign tree_mgt_free_ready = !empty;
    assign tree_mgt_full       = full;
    assign tree_mgt_empty      = empty;
    assign tree_mgt_used       = used_q;
    assign tree_mgt_err        = err_q;

    assign alloc_hs  = tree_mgt_req_valid & !full;
    assign free_hs   = tree_mgt_free_valid & !empty;
    assign free_take = free_hs & free_ok;
    assign misuse    = (tree_mgt_req_valid & full) | (tree_mgt_free_valid & empty) | (free_hs & !free_ok);

`ifdef TREE_SPACE_CHECK_EN
    logic [RAM_DEPTH-1:0] bitmap_q, bitmap_d;

    // A release only counts if it names a slot that is currently handed out.
    assign free_ok = ({1'b0, tree_mgt_free_addr} < DEPTH_CNT) && bitmap_q[tree_mgt_free_addr];

    always_comb begin
        bitmap_d = bitmap_q;
        if (tree_mgt_clear) begin
            bitmap_d = '0;
        end else begin
            if (free_take) bitmap_d[tree_mgt_free_addr] = 1'b0;
            if (alloc_hs)  bitmap_d[tree_mgt_req_addr]  = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) bitmap_q <= '0;
        else          bitmap_q <= bitmap_d;
    end
`else
    assign free_ok = 1'b1;
`endif

    // A same-cycle grant and release reuse the popped stack slot for the released address.
    always_comb begin
        bump_d     = bump_q;
        sp_d       = sp_q;
        used_d     = used_q;
        err_d      = err_q | misuse;
        stack_we   = 1'b0;
        stack_widx = push_idx;
        if (tree_mgt_clear) begin
            bump_d = '0;
            sp_d   = '0;
            used_d = '0;
            err_d  = 1'b0;
        end else begin
            case ({alloc_hs, free_take})
                2'b10: begin
                    if (stack_nonempty)  sp_d   = sp_q - ONE;
                    else if (bump_room)  bump_d = bump_q + ONE;
                    used_d = used_q + ONE;
                end
                2'b01: begin
                    stack_we = 1'b1;
                    sp_d     = sp_q + ONE;
                    used_d   = used_q - ONE;
                end
                2'b11: begin
                    stack_we = 1'b1;
                    if (stack_nonempty) begin
                        stack_widx = top_idx;
                    end else begin
                        if (bump_room) bump_d = bump_q + ONE;
                        sp_d = sp_q + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bump_q <= '0;
            sp_q   <= '0;
            used_q <= '0;
            err_q  <= 1'b0;
        end else begin
            bump_q <= bump_d;
            sp_q   <= sp_d;
            used_q <= used_d;
            err_q  <= err_d;
        end
    end

    // Stack contents are don't-care once the pointer is reset, so no reset here.
    always_ff @(posedge aclk) begin
        if (stack_we) stack_mem[stack_widx] <= tree_mgt_free_addr;
    end

endmodule

// File: tb/tb_tree_space_allocator.sv
// Testbench for tree_space_allocator: directed vector table, corner sequences, random run vs queue model.
// Builds with or without TREE_SPACE_CHECK_EN.

module tb_tree_space_allocator;

    localparam int AW    = 4;
    localparam int DEPTH = 10;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          clear = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          free_valid = 1'b0;
    logic          free_ready;
    logic [AW-1:0] free_addr = '0;
    logic          full, empty, err;
    logic [AW:0]   used;

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    tree_space_allocator #(.RAM_ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .tree_mgt_clear      (clear),
        .tree_mgt_req_valid  (req_valid),
        .tree_mgt_req_ready  (req_ready),
        .tree_mgt_req_addr   (req_addr),
        .tree_mgt_free_valid (free_valid),
        .tree_mgt_free_ready (free_ready),
        .tree_mgt_free_addr  (free_addr),
        .tree_mgt_full       (full),
        .tree_mgt_empty      (empty),
        .tree_mgt_used       (used),
        .tree_mgt_err        (err)
    );

    typedef struct {
        bit rv;
        bit fv;
        int fa;
        bit clr;
        bit chk_grant;
        int grant;
        int exp_used;
        bit exp_full;
        bit exp_empty;
        bit exp_err;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: LIFO of released addresses, fresh-slot counter, allocation map.
    int mstk[$];
    int mbump;
    int mused;
    bit merr;
    bit malloc[16];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit rv, input bit fv, input int fa, input bit clr);
        req_valid  = rv;
        free_valid = fv;
        free_addr  = AW'(fa);
        clear      = clr;
    endtask

    task automatic cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic checkIdle(input string tag, input int exp_used, input bit exp_err);
        checkOutput({tag, "_used"},       used,       exp_used);
        checkOutput({tag, "_full"},       full,       exp_used == DEPTH);
        checkOutput({tag, "_empty"},      empty,      exp_used == 0);
        checkOutput({tag, "_req_ready"},  req_ready,  exp_used != DEPTH);
        checkOutput({tag, "_free_ready"}, free_ready, exp_used != 0);
        checkOutput({tag, "_err"},        err,        exp_err);
    endtask

    function automatic void addVec(bit rv, bit fv, int fa, bit clr, bit chk, int grant,
                                   int u, bit f, bit e, bit er);
        vec_t v;
        v.rv = rv; v.fv = fv; v.fa = fa; v.clr = clr; v.chk_grant = chk; v.grant = grant;
        v.exp_used = u; v.exp_full = f; v.exp_empty = e; v.exp_err = er;
        vecs.push_back(v);
    endfunction

    function automatic void modelReset();
        mstk.delete();
        mbump = 0;
        mused = 0;
        merr  = 1'b0;
        foreach (malloc[i]) malloc[i] = 1'b0;
    endfunction

    function automatic int pickFreeAddr();
        int start;
        if ($urandom_range(0, 99) < 20) return int'($urandom_range(0, 15));
        start = int'($urandom_range(0, DEPTH - 1));
        for (int k = 0; k < DEPTH; k++) begin
            if (malloc[(start + k) % DEPTH]) return (start + k) % DEPTH;
        end
        return start;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Vector table: fill, LIFO reuse, overlapped grant/release, misuse and clear.
        for (int i = 0; i < DEPTH; i++) addVec(1, 0, 0, 0, 1, i, i + 1, i == DEPTH - 1, 0, 0);
        addVec(0, 1, 3, 0, 0, 0, 9, 0, 0, 0);
        addVec(0, 1, 7, 0, 0, 0, 8, 0, 0, 0);
        addVec(1, 0, 0, 0, 1, 7, 9, 0, 0, 0);
        addVec(1, 0, 0, 0, 1, 3, 10, 1, 0, 0);
        addVec(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) addVec(1, 0, 0, 0, 1, i, i + 1, 0, 0, 0);
        addVec(0, 1, 0, 0, 0, 0, 5, 0, 0, 0);
        addVec(0, 1, 5, 0, 0, 0, 4, 0, 0, 0);
        addVec(1, 1, 2, 0, 1, 5, 4, 0, 0, 0);
        addVec(1, 0, 0, 0, 1, 2, 5, 0, 0, 0);
        addVec(1, 0, 0, 0, 1, 0, 6, 0, 0, 0);
        addVec(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        addVec(0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        addVec(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        addVec(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        addVec(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);

        #2;
        checkOutput("reset_req_addr", req_addr, 0);
        checkIdle("reset", 0, 0);
        #10 aresetn = 1'b1;
        cycle();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rv, vecs[i].fv, vecs[i].fa, vecs[i].clr);
            #3;
            if (vecs[i].chk_grant) checkOutput($sformatf("vec%0d_grant", i), req_addr, vecs[i].grant);
            cycle();
            checkOutput($sformatf("vec%0d_used", i),  used,       vecs[i].exp_used);
            checkOutput($sformatf("vec%0d_full", i),  full,       vecs[i].exp_full);
            checkOutput($sformatf("vec%0d_empty", i), empty,      vecs[i].exp_empty);
            checkOutput($sformatf("vec%0d_err", i),   err,        vecs[i].exp_err);
            checkOutput($sformatf("vec%0d_rdy", i),   req_ready,  !vecs[i].exp_full);
            checkOutput($sformatf("vec%0d_frdy", i),  free_ready, !vecs[i].exp_empty);
            applyStimulus(0, 0, 0, 0);
        end

        // Asynchronous reset in the middle of a grant burst.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 0, 0);
            cycle();
        end
        checkOutput("burst_used", used, 6);
        aresetn = 1'b0;
        #1;
        checkOutput("midreset_req_addr", req_addr, 0);
        checkIdle("midreset", 0, 0);
        applyStimulus(0, 0, 0, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        cycle();
        applyStimulus(1, 0, 0, 0);
        #3;
        checkOutput("postreset_grant", req_addr, 0);
        cycle();
        checkIdle("postreset", 1, 0);
        applyStimulus(0, 0, 0, 1);
        cycle();

`ifdef TREE_SPACE_CHECK_EN
        // Double release and out-of-range release are accepted but dropped.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0);
            cycle();
        end
        applyStimulus(0, 1, 1, 0);
        cycle();
        checkIdle("chk_rel1", 2, 0);
        applyStimulus(0, 1, 1, 0);
        #3;
        checkOutput("chk_dup_frdy", free_ready, 1);
        cycle();
        checkIdle("chk_dup", 2, 1);
        applyStimulus(0, 1, 12, 0);
        cycle();
        checkIdle("chk_range", 2, 1);
        applyStimulus(1, 0, 0, 0);
        #3;
        checkOutput("chk_regrant", req_addr, 1);
        cycle();
        applyStimulus(1, 0, 0, 0);
        #3;
        checkOutput("chk_fresh", req_addr, 3);
        cycle();
        checkIdle("chk_end", 4, 1);
        applyStimulus(0, 0, 0, 1);
        cycle();
`endif

        // Randomised run against the queue model, alternating fill-heavy and drain-heavy phases.
        applyStimulus(0, 0, 0, 1);
        cycle();
        modelReset();
        for (int n = 0; n < 2000; n++) begin
            bit rv, fv, clr, fill, ah, fh, ok;
            int fa, exp_addr, g;
            fill = ((n / 60) % 2) == 0;
            rv   = $urandom_range(0, 99) < (fill ? 70 : 30);
            fv   = $urandom_range(0, 99) < (fill ? 30 : 70);
            clr  = $urandom_range(0, 299) == 0;
            fa   = pickFreeAddr();
            applyStimulus(rv, fv, fa, clr);
            #3;
            exp_addr = (mstk.size() != 0) ? mstk[$] : mbump;
            if (mused != DEPTH) checkOutput("rnd_req_addr", req_addr, exp_addr);
            checkOutput("rnd_req_ready",  req_ready,  mused != DEPTH);
            checkOutput("rnd_free_ready", free_ready, mused != 0);

            if (clr) begin
                modelReset();
            end else begin
                ah = rv && (mused != DEPTH);
                fh = fv && (mused != 0);
                ok = 1'b1;
`ifdef TREE_SPACE_CHECK_EN
                ok = (fa < DEPTH) && malloc[fa];
`endif
                if ((rv && mused == DEPTH) || (fv && mused == 0) || (fh && !ok)) merr = 1'b1;
                if (ah) begin
                    if (mstk.size() != 0) begin
                        g = mstk.pop_back();
                    end else begin
                        g = mbump;
                        if (mbump < DEPTH) mbump++;
                    end
                    malloc[g] = 1'b1;
                    mused++;
                end
                if (fh && ok) begin
                    malloc[fa] = 1'b0;
                    mstk.push_back(fa);
                    mused--;
                end
            end
            cycle();
            checkOutput("rnd_used",  used,  mused);
            checkOutput("rnd_full",  full,  mused == DEPTH);
            checkOutput("rnd_empty", empty, mused == 0);
            checkOutput("rnd_err",   err,   merr);
        end
        applyStimulus(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
